// File: rtl/adc_pkg.sv
// Shared types and constants for the LTC2308 reader: FSM encoding, word widths
// and the 6-bit single-ended configuration word sent to the ADC.
package adc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StConvst,
    StWait,
    StShift,
    StDone
  } adc_state_e;

  localparam int unsigned ADC_BITS    = 12;
  localparam int unsigned DATA_W      = 13;
  localparam int unsigned CFG_BITS    = 6;
  localparam int unsigned SCK_PERIODS = 12;

  localparam logic SD_SINGLE    = 1'b1;
  localparam logic UNI_UNIPOLAR = 1'b1;
  localparam logic SLP_OFF      = 1'b0;

  // Field order on the wire: S/D, O/S, S1, S0, UNI, SLP.
  function automatic logic [CFG_BITS-1:0] cfg_word(input logic [2:0] ch);
    return {SD_SINGLE, ch[0], ch[2], ch[1], UNI_UNIPOLAR, SLP_OFF};
  endfunction

endpackage

// File: rtl/adc_ltc2308_reader_if.sv
// Pin bundle between the reader (master) and the LTC2308 converter (slave).
interface adc_ltc2308_reader_if;

  logic ADC_CONVST;
  logic ADC_SCK;
  logic ADC_SDI;
  logic ADC_SDO;

  modport master (
    output ADC_CONVST,
    output ADC_SCK,
    output ADC_SDI,
    input  ADC_SDO
  );

  modport slave (
    input  ADC_CONVST,
    input  ADC_SCK,
    input  ADC_SDI,
    output ADC_SDO
  );

endinterface

// File: rtl/adc_sck_gen.sv
// SCK generator: while enabled, emits SCK_PERIODS high-then-low periods of
// 2*CLK_DIV clk cycles with rise/fall strobes and a last-period flag.
module adc_sck_gen
  import adc_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall,
  output logic last
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PerW = $clog2(SCK_PERIODS + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PerW-1:0] per_q, per_d;
  logic            sck_q, sck_d;
  logic            tick;

  assign tick = (cnt_q == '0);

  // Strobes mark the cycle whose closing edge moves SCK, so data launched on
  // that edge is already settled for a full half-period.
  assign rise = en && tick && !sck_q && (per_q < PerW'(SCK_PERIODS));
  assign fall = en && tick && sck_q;
  // Independent of en: the FSM derives en from its next state.
  assign last = tick && !sck_q && (per_q == PerW'(SCK_PERIODS));

  always_comb begin
    cnt_d = cnt_q;
    per_d = per_q;
    sck_d = sck_q;
    if (!en) begin
      cnt_d = '0;
      per_d = '0;
      sck_d = 1'b0;
    end else if (tick) begin
      if (rise || fall) begin
        sck_d = ~sck_q;
        cnt_d = CntW'(CLK_DIV - 1);
      end
      if (fall) begin
        per_d = per_q + PerW'(1);
      end
    end else begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      per_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      per_q <= per_d;
      sck_q <= sck_d;
    end
  end

  assign sck = sck_q;

endmodule

// File: rtl/adc_ltc2308_reader.sv
// LTC2308 frame master: CONVST pulse, conversion wait, 12-bit SPI shift, and a
// one-frame-late result realigned with the channel it was configured for.
module adc_ltc2308_reader
  import adc_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 2,
  parameter int unsigned CONVST_CYCLES = 2,
  parameter int unsigned CONV_CYCLES   = 80
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        channel,
  output logic              busy,
  output logic [DATA_W-1:0] data,
  output logic [2:0]        data_ch,
  output logic              valid,
  adc_ltc2308_reader_if.master adc
);

  localparam int unsigned CntMax = (CONVST_CYCLES > CONV_CYCLES) ? CONVST_CYCLES : CONV_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  adc_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic sck, sck_rise, sck_fall, sck_last, sck_en;
  logic frame_start, done_entry;

  logic busy_q, busy_d;
  logic convst_q, convst_d;
  logic valid_q, valid_d;

  logic [2:0]          cur_ch_q, prev_ch_q;
  logic                prime_q;
  logic [ADC_BITS-1:0] shift_q;
  logic [CFG_BITS-1:0] sdi_sr_q;
  logic [DATA_W-1:0]   data_q;
  logic [2:0]          data_ch_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StConvst;
      StConvst: if (cnt_q == CntW'(CONVST_CYCLES - 1)) state_d = StWait;
      StWait:   if (cnt_q == CntW'(CONV_CYCLES - 1)) state_d = StShift;
      StShift:  if (sck_last) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    cnt_d = (state_d != state_q || state_q == StIdle) ? '0 : cnt_q + CntW'(1);
  end

  // Output logic: registered so every pin changes only on a clock edge
  always_comb begin
    busy_d   = (state_d != StIdle);
    convst_d = (state_d == StConvst);
    valid_d  = (state_d == StDone) && !prime_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      convst_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      convst_q <= convst_d;
      valid_q  <= valid_d;
    end
  end

  // Enabled from the next state so the first SCK rise coincides with SHIFT entry.
  assign sck_en      = (state_d == StShift);
  assign frame_start = (state_q == StIdle) && (state_d == StConvst);
  assign done_entry  = (state_d == StDone);

  adc_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sck_en),
    .sck   (sck),
    .rise  (sck_rise),
    .fall  (sck_fall),
    .last  (sck_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ch_q  <= '0;
      prev_ch_q <= '0;
      prime_q   <= 1'b1;
      shift_q   <= '0;
      sdi_sr_q  <= '0;
      data_q    <= '0;
      data_ch_q <= '0;
    end else begin
      if (frame_start) begin
        cur_ch_q  <= channel;
        prev_ch_q <= cur_ch_q;
        sdi_sr_q  <= cfg_word(channel);
      end else if (sck_fall) begin
        // Zero fill drives SDI low for SCK periods 7-12.
        sdi_sr_q <= {sdi_sr_q[CFG_BITS-2:0], 1'b0};
      end
      if (sck_rise) begin
        shift_q <= {shift_q[ADC_BITS-2:0], adc.ADC_SDO};
      end
      if (done_entry) begin
        prime_q <= 1'b0;
        // The shifted result belongs to the previous frame's configuration.
        if (!prime_q) begin
          data_q    <= {1'b0, shift_q};
          data_ch_q <= prev_ch_q;
        end
      end
    end
  end

  assign busy           = busy_q;
  assign valid          = valid_q;
  assign data           = data_q;
  assign data_ch        = data_ch_q;
  assign adc.ADC_CONVST = convst_q;
  assign adc.ADC_SCK    = sck;
  assign adc.ADC_SDI    = sdi_sr_q[CFG_BITS-1];

endmodule
